// File: rtl/running_light_pkg.sv
// running_light_pkg: mode-select constants, key FSM states and mode stepping shared by the running-light blocks
package running_light_pkg;
  localparam int MODE_W = 2;
  localparam logic [MODE_W-1:0] MODE_0 = 2'd0;
  localparam logic [MODE_W-1:0] MODE_1 = 2'd1;
  localparam logic [MODE_W-1:0] MODE_2 = 2'd2;
  localparam logic [MODE_W-1:0] MODE_3 = 2'd3;
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} key_state_t;
  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
    return m == MODE_0 ? MODE_1 : m == MODE_1 ? MODE_2 : m == MODE_2 ? MODE_3 : MODE_0;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer; clk, rst (async active-low), d_i raw input, q_o synchronized output resetting to RST_VAL
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end
endmodule

// File: rtl/key_mode_select.sv
// key_mode_select: debounced push button stepping a 2-bit mode code; clk, rst (async active-low), key_n raw button (0 = pressed),
// S mode code, mode_pulse one-cycle strobe on each S update, key_level debounced button state (1 = pressed)
module key_mode_select
  import running_light_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 3,
  parameter int LONG_PRESS_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_n,
  output logic [MODE_W-1:0] S,
  output logic              mode_pulse,
  output logic              key_level
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  logic              key_s;
  key_state_t        state_q, state_d;
  logic [DW-1:0]     deb_q, deb_d;
  logic [HW-1:0]     hold_q, hold_d, hold_inc;
  logic              long_q, long_d;
  logic [MODE_W-1:0] s_q, s_d;
  logic              pulse_q, pulse_d;
  logic              level_q, level_d;
  logic              deb_last, hold_hit, finish_press, finish_rel;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(key_n),
    .q_o(key_s)
  );
  assign deb_last = int'(deb_q) == DEBOUNCE_CYCLES - 1;
  // Threshold fires once per press; a bounce back into HELD keeps long_q so it cannot refire.
  assign hold_hit = !long_q && int'(hold_q) == LONG_PRESS_CYCLES - 1;
  assign hold_inc = int'(hold_q) == LONG_PRESS_CYCLES ? hold_q : hold_q + 1'b1;
  always_comb begin
    state_d      = state_q;
    deb_d        = deb_q;
    hold_d       = hold_q;
    long_d       = long_q;
    s_d          = s_q;
    pulse_d      = 1'b0;
    level_d      = level_q;
    finish_press = 1'b0;
    finish_rel   = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_s) deb_d = '0;
        else if (DEBOUNCE_CYCLES == 1) finish_press = 1'b1;
        else begin
          state_d = PRESS_CHK;
          deb_d   = DW'(1);
        end
      end
      PRESS_CHK: begin
        if (key_s) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_last) finish_press = 1'b1;
        else deb_d = deb_q + 1'b1;
      end
      HELD: begin
        hold_d = hold_inc;
        if (hold_hit) begin
          s_d     = MODE_0;
          pulse_d = 1'b1;
          long_d  = 1'b1;
        end
        if (key_s) begin
          if (DEBOUNCE_CYCLES == 1) finish_rel = 1'b1;
          else begin
            state_d = REL_CHK;
            deb_d   = DW'(1);
          end
        end
      end
      REL_CHK: begin
        if (!key_s) state_d = HELD;
        else if (deb_last) finish_rel = 1'b1;
        else deb_d = deb_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (finish_press) begin
      state_d = HELD;
      level_d = 1'b1;
      hold_d  = '0;
      long_d  = 1'b0;
      deb_d   = '0;
    end
    // long_d rather than long_q: a threshold on this same edge suppresses the release step.
    if (finish_rel) begin
      state_d = IDLE;
      level_d = 1'b0;
      deb_d   = '0;
      if (!long_d) begin
        s_d     = next_mode(s_q);
        pulse_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      deb_q   <= '0;
      hold_q  <= '0;
      long_q  <= 1'b0;
      s_q     <= MODE_0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      hold_q  <= hold_d;
      long_q  <= long_d;
      s_q     <= s_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end
  assign S          = s_q;
  assign mode_pulse = pulse_q;
  assign key_level  = level_q;
endmodule

// File: tb/tb_key_mode_select.sv
// tb_key_mode_select: directed vector table plus hand sequences for key_mode_select with DEBOUNCE_CYCLES=3, LONG_PRESS_CYCLES=10
module tb_key_mode_select;
  typedef struct {
    logic       r;
    logic       k;
    logic [1:0] s;
    logic       p;
    logic       l;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst;
  logic       key_n;
  logic [1:0] mode_s;
  logic       mode_pulse;
  logic       key_level;
  int         n_vec = 0;
  int         n_bad = 0;
  int         vi = 0;
  vec_t       q[$];
  key_mode_select #(.DEBOUNCE_CYCLES(3), .LONG_PRESS_CYCLES(10)) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .S(mode_s),
    .mode_pulse(mode_pulse),
    .key_level(key_level)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [1:0] s, input logic p, input logic l);
    n_vec++;
    if (mode_s !== s || mode_pulse !== p || key_level !== l) begin
      n_bad++;
      $display("FAIL %s: got S=%0d pulse=%b level=%b, expected S=%0d pulse=%b level=%b",
               name, mode_s, mode_pulse, key_level, s, p, l);
    end
  endtask
  task automatic add(input logic r, input logic k, input logic [1:0] s, input logic p, input logic l);
    q.push_back('{r, k, s, p, l});
  endtask
  // 8 low samples then 6 high: level rises on the 5th low edge, S steps on the 5th high edge
  task automatic add_press(input logic [1:0] s0);
    logic [1:0] s1;
    s1 = s0 + 2'd1;
    for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, s0, 1'b0, i >= 5);
    for (int i = 1; i <= 6; i++) add(1'b1, 1'b1, i >= 5 ? s1 : s0, i == 5, i < 5);
  endtask
  task automatic run();
    foreach (q[i]) begin
      rst   = q[i].r;
      key_n = q[i].k;
      @(negedge clk);
      check($sformatf("vec%0d", vi), q[i].s, q[i].p, q[i].l);
      vi++;
    end
    q.delete();
  endtask
  initial begin
    logic [1:0] rel_keys;
    rst   = 1'b0;
    key_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) add(1'b0, i[0], 2'd0, 1'b0, 1'b0);
    add_press(2'd0);
    for (int i = 1; i <= 8; i++) add(1'b1, i > 4 ? 1'b1 : i[0] == 1'b0, 2'd1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, 2'd1, 1'b0, i >= 5);
    rel_keys = 2'b01;
    for (int i = 1; i <= 8; i++) add(1'b1, i <= 2 ? rel_keys[i-1] : 1'b1, i >= 7 ? 2'd2 : 2'd1, i == 7, i < 7);
    add_press(2'd2);
    add(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) add_press(2'(i));
    add_press(2'd0);
    add_press(2'd1);
    for (int i = 1; i <= 20; i++) add(1'b1, 1'b0, i >= 15 ? 2'd0 : 2'd2, i == 15, i >= 5);
    for (int i = 1; i <= 6; i++) add(1'b1, 1'b1, 2'd0, 1'b0, i < 5);
    add_press(2'd0);
    for (int i = 1; i <= 12; i++) add(1'b1, 1'b0, 2'd1, 1'b0, i >= 5);
    for (int i = 1; i <= 7; i++) add(1'b1, 1'b1, i >= 3 ? 2'd0 : 2'd1, i == 3, i < 5);
    add_press(2'd0);
    add_press(2'd1);
    add_press(2'd2);
    for (int i = 1; i <= 6; i++) add(1'b1, 1'b0, 2'd3, 1'b0, i >= 5);
    run();
    #2 rst = 1'b0;
    #1 check("rst_async", 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_hold", 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    add_press(2'd0);
    run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
